xif_bitmanip_coproc: RTL and testbench
======================================

// Module: xif_bitmanip_coproc
// PURPOSE
// - CORE-V-XIF coprocessor on the far side of the cv32e40px XIF ports: issue, commit and result channels.
// - Accepts custom-0 bit-manipulation instructions and computes each result at issue.
// - Buffers results in an in-order slot queue until commit; killed slots are dropped.
// - Returns committed results over the result channel with ready/valid backpressure.
// PARAMETERS
// - DEPTH       default 4      outstanding slots; power of two, >= 2
// - X_ID_WIDTH  default 4      width of the XIF instruction id
// - OPCODE      default 7'h0B  major opcode claimed (custom-0)
// PORTS
// - clk_i             in   1           clock
// - rst_ni            in   1           async active-low reset
// - issue_valid_i     in   1           issue request valid
// - issue_ready_o     out  1           issue request ready
// - issue_instr_i     in   32          offloaded instruction
// - issue_id_i        in   X_ID_WIDTH  instruction id
// - issue_rs_i        in   64          {rs2,rs1} operands
// - issue_rs_valid_i  in   2           operand valid bits [1]=rs2, [0]=rs1
// - issue_accept_o    out  1           instruction accepted (valid while valid&ready)
// - issue_writeback_o out  1           accepted instruction writes rd
// - commit_valid_i    in   1           commit strobe
// - commit_id_i       in   X_ID_WIDTH  id being committed or killed
// - commit_kill_i     in   1           1 = kill, 0 = commit
// - result_valid_o    out  1           result valid
// - result_ready_i    in   1           CPU ready for result
// - result_id_o       out  X_ID_WIDTH  id of returned result
// - result_data_o     out  32          result value
// - result_rd_o       out  5           destination register
// - result_we_o       out  1           write enable; always 1 when result_valid_o=1
// BEHAVIOUR
// - Decode, combinational: match = opcode==OPCODE && funct7==0.
//   - funct3 000: CPOP rs1 (popcount, 0..32).
//   - funct3 001: CLZ rs1; result 32 when rs1==0.
//   - funct3 010: ROL rs1, rs2[4:0] (only under the macro below).
//   - Any other encoding: not accepted.
// - Operand need: CPOP/CLZ need rs1; ROL needs rs1 and rs2.
// - issue_ready_o = count<DEPTH && all needed rs_valid bits set.
//   - Non-matching instructions need no operands: issue_ready_o=1 whenever count<DEPTH.
// - Issue response, combinational, same cycle as the handshake:
//   - issue_accept_o = issue_writeback_o = match.
//   - Both are 0 whenever issue_valid_i=0.
// - Slot queue: circular buffer with wr_ptr, rd_ptr and count.
//   - Each slot holds {id, rd, data, state}; state in {FREE, ISSUED, COMMITTED, KILLED}.
//   - An accepted handshake writes slot[wr_ptr] = ISSUED and increments wr_ptr.
// - Commit: the first ISSUED slot whose id == commit_id_i becomes KILLED (kill=1) or COMMITTED (kill=0).
//   - A commit that matches no ISSUED slot is ignored (non-accepted instruction).
//   - A commit in the same cycle as an accepted issue with the same id applies to the new slot.
// - Head handling at slot[rd_ptr]:
//   - KILLED: freed silently, 1 slot/cycle.
//   - COMMITTED: result_valid_o=1 from the cycle after commit (registered state); freed on valid&ready.
//   - ISSUED or FREE: result_valid_o=0.
// - Result outputs are driven directly from slot[rd_ptr]. They are stable while valid && !ready.
// - Same-cycle pop and accepted issue are both performed; count is unchanged; issue is allowed when full only if the head pops that cycle.
// - Results return strictly in issue order. Minimum latency: issue -> commit (next cycle) -> result_valid_o the cycle after.
// - Pointers wrap modulo DEPTH. count is $clog2(DEPTH)+1 bits wide.
// - Reset, any time including mid-operation:
//   - All slots FREE, pointers and count 0; outstanding instructions are discarded.
//   - result_valid_o=0, result_id_o=0, result_data_o=0, result_rd_o=0, result_we_o=0.
//   - issue_accept_o=0, issue_writeback_o=0, issue_ready_o=1.
// CONFIGURATION
// - XIF_BITMANIP_ROT_EN defined: funct3 010 (ROL) is decoded, needs rs2, result = rs1 rotated left by rs2[4:0].
// - Macro undefined: funct3 010 is not accepted (accept=0, writeback=0); the rotator is not synthesized.
// TESTING
// - Reset, then issue CPOP id=1 rs1=32'hF0F0_0001: accept=1 same cycle.
//   - Commit id=1 kill=0; next cycle result_valid_o=1, data=9, rd=instr[11:7], id=1.
// - CLZ rs1=0 -> data=32. CLZ rs1=32'h0000_8000 -> data=16.
// - Issue opcode 7'h33: issue_ready_o=1, accept=0; commit of that id leaves count unchanged.
// - Issue DEPTH=4 accepted ids 0..3 with result_ready_i=0: issue_ready_o=0 while full.
//   - Commit all, then raise ready: results return as ids 0,1,2,3, one per cycle.
// - Issue ids 4,5,6; kill id 5; commit 4 and 6: only ids 4 and 6 are returned, in order.
// - With XIF_BITMANIP_ROT_EN: ROL rs1=32'h8000_0001 rs2=1 -> data=32'h0000_0003.
//   - Same ROL with rs_valid=2'b01 stalls (ready=0).
//   - Without the macro, ROL gets accept=0.
// - Assert rst_ni with 2 committed results pending: after release, result_valid_o=0 and count=0.

Source files
------------

// File: rtl/xif_bitmanip_coproc.sv
// CORE-V-XIF bit-manipulation coprocessor: CPOP/CLZ (and optional ROL) on custom-0, with
// in-order result slots released on commit. Define XIF_BITMANIP_ROT_EN to decode ROL.
module xif_bitmanip_coproc #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned X_ID_WIDTH = 4,
  parameter logic [6:0]  OPCODE     = 7'h0B
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  issue_valid_i,
  output logic                  issue_ready_o,
  input  logic [31:0]           issue_instr_i,
  input  logic [X_ID_WIDTH-1:0] issue_id_i,
  input  logic [63:0]           issue_rs_i,
  input  logic [1:0]            issue_rs_valid_i,
  output logic                  issue_accept_o,
  output logic                  issue_writeback_o,
  input  logic                  commit_valid_i,
  input  logic [X_ID_WIDTH-1:0] commit_id_i,
  input  logic                  commit_kill_i,
  output logic                  result_valid_o,
  input  logic                  result_ready_i,
  output logic [X_ID_WIDTH-1:0] result_id_o,
  output logic [31:0]           result_data_o,
  output logic [4:0]            result_rd_o,
  output logic                  result_we_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

  typedef enum logic [1:0] {SlotFree, SlotIssued, SlotCommitted, SlotKilled} slot_state_e;

  slot_state_e           state_q [DEPTH];
  slot_state_e           state_d [DEPTH];
  logic [X_ID_WIDTH-1:0] id_q    [DEPTH];
  logic [X_ID_WIDTH-1:0] id_d    [DEPTH];
  logic [4:0]            rd_q    [DEPTH];
  logic [4:0]            rd_d    [DEPTH];
  logic [31:0]           data_q  [DEPTH];
  logic [31:0]           data_d  [DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]       count_q, count_d;

  // Decode
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  instr_rd;
  logic [31:0] rs1, rs2;
  logic        dec_ok, is_cpop, is_clz, is_rol, match;

  assign opcode   = issue_instr_i[6:0];
  assign instr_rd = issue_instr_i[11:7];
  assign funct3   = issue_instr_i[14:12];
  assign funct7   = issue_instr_i[31:25];
  assign rs1      = issue_rs_i[31:0];
  assign rs2      = issue_rs_i[63:32];
  assign dec_ok   = (opcode == OPCODE) && (funct7 == 7'd0);
  assign is_cpop  = dec_ok && (funct3 == 3'b000);
  assign is_clz   = dec_ok && (funct3 == 3'b001);

  logic [31:0] rol_res;
`ifdef XIF_BITMANIP_ROT_EN
  logic [5:0] rol_rsh;
  assign is_rol  = dec_ok && (funct3 == 3'b010);
  // A right shift by 32 yields zero, so a rotate amount of 0 needs no special case.
  assign rol_rsh = 6'd32 - {1'b0, rs2[4:0]};
  assign rol_res = (rs1 << rs2[4:0]) | (rs1 >> rol_rsh);
  logic unused_bits;
  assign unused_bits = ^{issue_instr_i[24:15], rs2[31:5]};
`else
  assign is_rol  = 1'b0;
  assign rol_res = 32'd0;
  logic unused_bits;
  assign unused_bits = ^{issue_instr_i[24:15], rs2, issue_rs_valid_i[1]};
`endif

  assign match = is_cpop || is_clz || is_rol;

  // Operand and capacity checks
  logic ops_ok, head_pop, space_ok, accept_fire;

  assign ops_ok = !issue_valid_i ||
                  ((!match || issue_rs_valid_i[0]) && (!is_rol || issue_rs_valid_i[1]));
  assign head_pop = (state_q[rd_ptr_q] == SlotKilled) ||
                    ((state_q[rd_ptr_q] == SlotCommitted) && result_ready_i);
  assign space_ok = (count_q < DepthCnt) || head_pop;

  assign issue_ready_o     = space_ok && ops_ok;
  assign issue_accept_o    = issue_valid_i && match;
  assign issue_writeback_o = issue_valid_i && match;
  assign accept_fire       = issue_valid_i && issue_ready_o && match;

  // Execution
  logic [5:0]  cpop_cnt, clz_cnt;
  logic [31:0] exec_res;

  always_comb begin
    cpop_cnt = 6'd0;
    clz_cnt  = 6'd32;
    for (int i = 0; i < 32; i++) begin
      cpop_cnt = cpop_cnt + {5'd0, rs1[i]};
      if (rs1[i]) clz_cnt = 6'(31 - i);
    end
  end

  always_comb begin
    exec_res = rol_res;
    if (is_cpop)     exec_res = {26'd0, cpop_cnt};
    else if (is_clz) exec_res = {26'd0, clz_cnt};
  end

  // Slot queue next state
  logic            commit_new, found;
  logic [PtrW-1:0] idx;
  slot_state_e     commit_state;

  assign commit_new   = commit_valid_i && accept_fire && (issue_id_i == commit_id_i);
  assign commit_state = commit_kill_i ? SlotKilled : SlotCommitted;

  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    rd_d     = rd_q;
    data_d   = data_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    found    = 1'b0;
    idx      = '0;

    if (head_pop) begin
      state_d[rd_ptr_q] = SlotFree;
      rd_ptr_d          = rd_ptr_q + 1'b1;
    end

    // Oldest-first search so duplicate ids resolve to the earliest outstanding slot.
    if (commit_valid_i && !commit_new) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        idx = rd_ptr_q + PtrW'(i);
        if (!found && (state_q[idx] == SlotIssued) && (id_q[idx] == commit_id_i)) begin
          state_d[idx] = commit_state;
          found        = 1'b1;
        end
      end
    end

    if (accept_fire) begin
      state_d[wr_ptr_q] = commit_new ? commit_state : SlotIssued;
      id_d[wr_ptr_q]    = issue_id_i;
      rd_d[wr_ptr_q]    = instr_rd;
      data_d[wr_ptr_q]  = exec_res;
      wr_ptr_d          = wr_ptr_q + 1'b1;
    end

    unique case ({accept_fire, head_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        state_q[i] <= SlotFree;
        id_q[i]    <= '0;
        rd_q[i]    <= '0;
        data_q[i]  <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      id_q     <= id_d;
      rd_q     <= rd_d;
      data_q   <= data_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Result channel straight from the head slot
  assign result_valid_o = (state_q[rd_ptr_q] == SlotCommitted);
  assign result_we_o    = result_valid_o;
  assign result_id_o    = id_q[rd_ptr_q];
  assign result_rd_o    = rd_q[rd_ptr_q];
  assign result_data_o  = data_q[rd_ptr_q];

endmodule

// File: tb/tb_xif_bitmanip_coproc.sv
// Directed self-checking bench for xif_bitmanip_coproc (DEPTH=4, 4-bit ids).
module tb_xif_bitmanip_coproc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_valid;
  logic        issue_ready;
  logic [31:0] issue_instr;
  logic [3:0]  issue_id;
  logic [63:0] issue_rs;
  logic [1:0]  issue_rs_valid;
  logic        issue_accept;
  logic        issue_writeback;
  logic        commit_valid;
  logic [3:0]  commit_id;
  logic        commit_kill;
  logic        result_valid;
  logic        result_ready;
  logic [3:0]  result_id;
  logic [31:0] result_data;
  logic [4:0]  result_rd;
  logic        result_we;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  xif_bitmanip_coproc #(
    .DEPTH      (4),
    .X_ID_WIDTH (4),
    .OPCODE     (7'h0B)
  ) dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .issue_valid_i     (issue_valid),
    .issue_ready_o     (issue_ready),
    .issue_instr_i     (issue_instr),
    .issue_id_i        (issue_id),
    .issue_rs_i        (issue_rs),
    .issue_rs_valid_i  (issue_rs_valid),
    .issue_accept_o    (issue_accept),
    .issue_writeback_o (issue_writeback),
    .commit_valid_i    (commit_valid),
    .commit_id_i       (commit_id),
    .commit_kill_i     (commit_kill),
    .result_valid_o    (result_valid),
    .result_ready_i    (result_ready),
    .result_id_o       (result_id),
    .result_data_o     (result_data),
    .result_rd_o       (result_rd),
    .result_we_o       (result_we)
  );

  function automatic logic [31:0] mk(input logic [2:0] f3, input logic [4:0] rd);
    return {7'd0, 5'd2, 5'd1, f3, rd, 7'h0B};
  endfunction

  task automatic drive_issue(input logic [31:0] instr, input logic [3:0] id,
                             input logic [31:0] rs1, input logic [31:0] rs2,
                             input logic [1:0] rv,
                             output logic acc, output logic wb, output logic rdy);
    @(negedge clk);
    issue_valid    = 1'b1;
    issue_instr    = instr;
    issue_id       = id;
    issue_rs       = {rs2, rs1};
    issue_rs_valid = rv;
    #2;
    acc = issue_accept;
    wb  = issue_writeback;
    rdy = issue_ready;
    @(posedge clk);
    #1;
    issue_valid    = 1'b0;
    issue_rs_valid = 2'b00;
  endtask

  task automatic drive_commit(input logic [3:0] id, input logic kill);
    @(negedge clk);
    commit_valid = 1'b1;
    commit_id    = id;
    commit_kill  = kill;
    @(posedge clk);
    #1;
    commit_valid = 1'b0;
  endtask

  task automatic get_result(output logic got, output logic [3:0] id,
                            output logic [31:0] data, output logic [4:0] rd);
    got  = 1'b0;
    id   = '0;
    data = '0;
    rd   = '0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      #2;
      if (result_valid) begin
        got          = 1'b1;
        id           = result_id;
        data         = result_data;
        rd           = result_rd;
        result_ready = 1'b1;
        @(posedge clk);
        #1;
        result_ready = 1'b0;
      end
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    #2;
    total++; if (result_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got %0h want 0", result_valid); end
    total++; if ({result_id, result_data, result_rd, result_we} !== 42'd0) begin bad++; $display("FAIL reset_result got id=%0h data=%0h rd=%0h we=%0h want 0", result_id, result_data, result_rd, result_we); end
    total++; if ({issue_ready, issue_accept, issue_writeback} !== 3'b100) begin bad++; $display("FAIL reset_issue got %b want 100", {issue_ready, issue_accept, issue_writeback}); end
    total++; if (dut.count_q !== 3'd0) begin bad++; $display("FAIL reset_count got %0d want 0", dut.count_q); end
  endtask

  task automatic test_cpop;
    logic acc, wb, rdy;
    drive_issue(mk(3'b000, 5'd5), 4'd1, 32'hF0F0_0001, 32'd0, 2'b01, acc, wb, rdy);
    total++; if ({acc, wb, rdy} !== 3'b111) begin bad++; $display("FAIL cpop_issue got %b want 111", {acc, wb, rdy}); end
    #1;
    total++; if (result_valid !== 1'b0) begin bad++; $display("FAIL cpop_precommit_valid got %0h want 0", result_valid); end
    drive_commit(4'd1, 1'b0);
    #1;
    total++; if ({result_valid, result_we} !== 2'b11) begin bad++; $display("FAIL cpop_valid got %b want 11", {result_valid, result_we}); end
    total++; if (result_data !== 32'd9) begin bad++; $display("FAIL cpop_data got %0d want 9", result_data); end
    total++; if ({result_id, result_rd} !== {4'd1, 5'd5}) begin bad++; $display("FAIL cpop_idrd got id=%0d rd=%0d want id=1 rd=5", result_id, result_rd); end
    @(negedge clk);
    result_ready = 1'b1;
    @(posedge clk);
    #1;
    result_ready = 1'b0;
    #1;
    total++; if (result_valid !== 1'b0 || dut.count_q !== 3'd0) begin bad++; $display("FAIL cpop_drain got valid=%0h count=%0d want 0 0", result_valid, dut.count_q); end
  endtask

  task automatic test_clz;
    logic acc, wb, rdy, got;
    logic [3:0] id;
    logic [31:0] data;
    logic [4:0] rd;
    drive_issue(mk(3'b001, 5'd6), 4'd2, 32'd0, 32'd0, 2'b01, acc, wb, rdy);
    total++; if (acc !== 1'b1) begin bad++; $display("FAIL clz0_accept got %0h want 1", acc); end
    drive_issue(mk(3'b001, 5'd7), 4'd3, 32'h0000_8000, 32'd0, 2'b01, acc, wb, rdy);
    total++; if (acc !== 1'b1) begin bad++; $display("FAIL clz16_accept got %0h want 1", acc); end
    drive_commit(4'd2, 1'b0);
    drive_commit(4'd3, 1'b0);
    get_result(got, id, data, rd);
    total++; if ({got, id, data, rd} !== {1'b1, 4'd2, 32'd32, 5'd6}) begin bad++; $display("FAIL clz_zero got got=%0d id=%0d data=%0d rd=%0d want 1 2 32 6", got, id, data, rd); end
    get_result(got, id, data, rd);
    total++; if ({got, id, data, rd} !== {1'b1, 4'd3, 32'd16, 5'd7}) begin bad++; $display("FAIL clz_8000 got got=%0d id=%0d data=%0d rd=%0d want 1 3 16 7", got, id, data, rd); end
  endtask

  task automatic test_nonmatch;
    logic acc, wb, rdy;
    drive_issue({7'd0, 5'd2, 5'd1, 3'b000, 5'd3, 7'h33}, 4'd7, 32'd1, 32'd1, 2'b00, acc, wb, rdy);
    total++; if ({rdy, acc, wb} !== 3'b100) begin bad++; $display("FAIL nonmatch_issue got %b want 100", {rdy, acc, wb}); end
    drive_commit(4'd7, 1'b0);
    #1;
    total++; if (dut.count_q !== 3'd0 || result_valid !== 1'b0) begin bad++; $display("FAIL nonmatch_commit got count=%0d valid=%0h want 0 0", dut.count_q, result_valid); end
  endtask

  task automatic test_full;
    logic acc, wb, rdy, got;
    logic [3:0] id;
    logic [31:0] data;
    logic [4:0] rd;
    logic [3:0] exp_id [3];
    logic [31:0] exp_data [3];
    exp_id   = '{4'd1, 4'd2, 4'd3};
    exp_data = '{32'd1, 32'd1, 32'd2};
    result_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_issue(mk(3'b000, 5'(i + 1)), 4'(i), 32'(i), 32'd0, 2'b01, acc, wb, rdy);
      total++; if (acc !== 1'b1 || rdy !== 1'b1) begin bad++; $display("FAIL full_fill%0d got acc=%0h rdy=%0h want 1 1", i, acc, rdy); end
    end
    @(negedge clk);
    issue_valid = 1'b1; issue_instr = mk(3'b000, 5'd1); issue_id = 4'd8;
    issue_rs = 64'd0; issue_rs_valid = 2'b01;
    #2;
    total++; if (issue_ready !== 1'b0) begin bad++; $display("FAIL full_stall got ready=%0h want 0", issue_ready); end
    @(posedge clk);
    #1;
    issue_valid = 1'b0;
    #1;
    total++; if (dut.count_q !== 3'd4) begin bad++; $display("FAIL full_count got %0d want 4", dut.count_q); end
    for (int i = 0; i < 4; i++) drive_commit(4'(i), 1'b0);
    // Full queue: a popping head must let a new issue through in the same cycle.
    @(negedge clk);
    result_ready = 1'b1;
    issue_valid = 1'b1; issue_instr = mk(3'b000, 5'd9); issue_id = 4'd10;
    issue_rs = 64'd0; issue_rs_valid = 2'b01;
    #2;
    total++; if ({issue_ready, issue_accept, result_valid, result_id} !== {3'b111, 4'd0}) begin bad++; $display("FAIL full_popissue got ready=%0h acc=%0h valid=%0h id=%0d want 1 1 1 0", issue_ready, issue_accept, result_valid, result_id); end
    @(posedge clk);
    #1;
    issue_valid = 1'b0;
    total++; if (dut.count_q !== 3'd4) begin bad++; $display("FAIL full_popissue_count got %0d want 4", dut.count_q); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #2;
      total++; if ({result_valid, result_id, result_data} !== {1'b1, exp_id[k], exp_data[k]}) begin bad++; $display("FAIL full_order%0d got valid=%0h id=%0d data=%0d want 1 %0d %0d", k, result_valid, result_id, result_data, exp_id[k], exp_data[k]); end
    end
    @(negedge clk);
    #2;
    total++; if (result_valid !== 1'b0) begin bad++; $display("FAIL full_uncommitted_head got valid=%0h want 0", result_valid); end
    result_ready = 1'b0;
    drive_commit(4'd10, 1'b0);
    get_result(got, id, data, rd);
    total++; if ({got, id, data, rd} !== {1'b1, 4'd10, 32'd0, 5'd9}) begin bad++; $display("FAIL full_last got got=%0d id=%0d data=%0d rd=%0d want 1 10 0 9", got, id, data, rd); end
  endtask

  task automatic test_kill;
    logic acc, wb, rdy, got;
    logic [3:0] id;
    logic [31:0] data;
    logic [4:0] rd;
    for (int i = 4; i < 7; i++) drive_issue(mk(3'b000, 5'(i)), 4'(i), 32'hF, 32'd0, 2'b01, acc, wb, rdy);
    drive_commit(4'd5, 1'b1);
    drive_commit(4'd4, 1'b0);
    drive_commit(4'd6, 1'b0);
    get_result(got, id, data, rd);
    total++; if ({got, id, data} !== {1'b1, 4'd4, 32'd4}) begin bad++; $display("FAIL kill_first got got=%0d id=%0d data=%0d want 1 4 4", got, id, data); end
    get_result(got, id, data, rd);
    total++; if ({got, id, data, rd} !== {1'b1, 4'd6, 32'd4, 5'd6}) begin bad++; $display("FAIL kill_second got got=%0d id=%0d data=%0d rd=%0d want 1 6 4 6", got, id, data, rd); end
    repeat (3) @(negedge clk);
    #2;
    total++; if (result_valid !== 1'b0 || dut.count_q !== 3'd0) begin bad++; $display("FAIL kill_empty got valid=%0h count=%0d want 0 0", result_valid, dut.count_q); end
  endtask

  task automatic test_same_cycle_commit;
    @(negedge clk);
    issue_valid = 1'b1; issue_instr = mk(3'b000, 5'd11); issue_id = 4'd11;
    issue_rs = {32'd0, 32'h0000_00FF}; issue_rs_valid = 2'b01;
    commit_valid = 1'b1; commit_id = 4'd11; commit_kill = 1'b0;
    @(posedge clk);
    #1;
    issue_valid = 1'b0; commit_valid = 1'b0;
    #1;
    total++; if ({result_valid, result_id, result_data} !== {1'b1, 4'd11, 32'd8}) begin bad++; $display("FAIL samecycle got valid=%0h id=%0d data=%0d want 1 11 8", result_valid, result_id, result_data); end
    @(negedge clk);
    result_ready = 1'b1;
    @(posedge clk);
    #1;
    result_ready = 1'b0;
  endtask

  task automatic test_rol;
    logic acc, wb, rdy;
`ifdef XIF_BITMANIP_ROT_EN
    logic got;
    logic [3:0] id;
    logic [31:0] data;
    logic [4:0] rd;
    drive_issue(mk(3'b010, 5'd12), 4'd12, 32'h8000_0001, 32'd1, 2'b01, acc, wb, rdy);
    total++; if (rdy !== 1'b0) begin bad++; $display("FAIL rol_stall got ready=%0h want 0", rdy); end
    drive_issue(mk(3'b010, 5'd12), 4'd12, 32'h8000_0001, 32'd1, 2'b11, acc, wb, rdy);
    total++; if ({acc, wb, rdy} !== 3'b111) begin bad++; $display("FAIL rol_issue got %b want 111", {acc, wb, rdy}); end
    drive_commit(4'd12, 1'b0);
    get_result(got, id, data, rd);
    total++; if ({got, id, data} !== {1'b1, 4'd12, 32'h0000_0003}) begin bad++; $display("FAIL rol_data got got=%0d id=%0d data=%0h want 1 12 3", got, id, data); end
`else
    drive_issue(mk(3'b010, 5'd12), 4'd12, 32'h8000_0001, 32'd1, 2'b11, acc, wb, rdy);
    total++; if ({acc, wb, rdy} !== 3'b001) begin bad++; $display("FAIL rol_disabled got %b want 001", {acc, wb, rdy}); end
    #1;
    total++; if (dut.count_q !== 3'd0) begin bad++; $display("FAIL rol_disabled_count got %0d want 0", dut.count_q); end
`endif
  endtask

  task automatic test_reset_mid;
    logic acc, wb, rdy;
    drive_issue(mk(3'b000, 5'd13), 4'd13, 32'h3, 32'd0, 2'b01, acc, wb, rdy);
    drive_issue(mk(3'b000, 5'd14), 4'd14, 32'h7, 32'd0, 2'b01, acc, wb, rdy);
    drive_commit(4'd13, 1'b0);
    drive_commit(4'd14, 1'b0);
    #1;
    total++; if ({result_valid, result_id, result_data} !== {1'b1, 4'd13, 32'd2}) begin bad++; $display("FAIL rstmid_pending got valid=%0h id=%0d data=%0d want 1 13 2", result_valid, result_id, result_data); end
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    total++; if ({result_valid, result_id, result_data, result_rd, result_we} !== 43'd0) begin bad++; $display("FAIL rstmid_outputs got valid=%0h id=%0d data=%0h rd=%0d we=%0h want 0", result_valid, result_id, result_data, result_rd, result_we); end
    total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL rstmid_ready got %0h want 1", issue_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #2;
    total++; if (result_valid !== 1'b0 || dut.count_q !== 3'd0) begin bad++; $display("FAIL rstmid_after got valid=%0h count=%0d want 0 0", result_valid, dut.count_q); end
  endtask

  initial begin
    rst_n          = 1'b0;
    issue_valid    = 1'b0;
    issue_instr    = 32'd0;
    issue_id       = 4'd0;
    issue_rs       = 64'd0;
    issue_rs_valid = 2'b00;
    commit_valid   = 1'b0;
    commit_id      = 4'd0;
    commit_kill    = 1'b0;
    result_ready   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    test_reset();
    test_cpop();
    test_clz();
    test_nonmatch();
    test_full();
    test_kill();
    test_same_cycle_commit();
    test_rol();
    test_reset_mid();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
